// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding and byte-lane helper.
// Optional build feature: IMEM_LOADER_CSUM_EN (trailing checksum byte).
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] lane_merge(
    input logic [31:0]       w,
    input logic [LANE_W-1:0] k,
    input logic [7:0]        b
  );
    logic [31:0] r;
    r = w;
    r[8*k +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: little-endian 4x8 lane register for imem_loader.
// word_o includes the byte being pushed this cycle; unfilled lanes read zero.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        flush_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        pending_o,
  output logic        emit_o
);

  logic [LANE_W-1:0] lane_q;
  logic [31:0]       lanes_q;
  logic              full;

  assign full      = push_i && (lane_q == 2'd3);
  assign emit_o    = full || flush_i;
  assign pending_o = (lane_q != 2'd0);
  assign word_o    = push_i ? lane_merge(lanes_q, lane_q, data_i)
                            : lanes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q  <= '0;
      lanes_q <= '0;
    end else if (clear_i || emit_o) begin
      lane_q  <= '0;
      lanes_q <= '0;
    end else if (push_i) begin
      lane_q  <= lane_q + 2'd1;
      lanes_q <= word_o;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into words, writes imem from word 0.
// Optional build feature: IMEM_LOADER_CSUM_EN (trailing checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int D_WIDTH     = 32,
  parameter int A_WIDTH     = 32,
  parameter int MEM_A_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 mem_we,
  output logic [A_WIDTH-1:0]   mem_addr,
  output logic [D_WIDTH-1:0]   mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [MEM_A_WIDTH:0] word_count,
  output logic                 cpu_hold
);

  localparam logic [MEM_A_WIDTH:0] CAP =
    {1'b1, {MEM_A_WIDTH{1'b0}}};

  state_t               state_q;
  logic [MEM_A_WIDTH:0] idx_q;
  logic [MEM_A_WIDTH:0] cnt_q;
  logic [7:0]           sum_q;
  logic [7:0]           sum_nxt;
  logic                 last_q;
  logic                 ready_q;
  logic                 we_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 hold_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   wdata_q;

  logic        take;
  logic        at_cap;
  logic        ovf;
  logic        is_data;
  logic        csum_bad;
  logic        push;
  logic        flush;
  logic        emit;
  logic        pending;
  logic        err_set;
  logic        restart;
  logic [31:0] word;

  assign take    = (state_q == S_LOAD) && s_valid && ready_q;
  assign at_cap  = (idx_q == CAP);
  assign ovf     = take && at_cap;
  assign sum_nxt = sum_q + s_data;

`ifdef IMEM_LOADER_CSUM_EN
  assign is_data  = !s_last;
  assign csum_bad = take && s_last && (sum_nxt != 8'd0);
`else
  assign is_data  = 1'b1;
  assign csum_bad = 1'b0;
`endif

  assign push    = take && !at_cap && is_data;
  // a lone checksum byte with no data lanes pending produces no write
  assign flush   = take && s_last && !at_cap && (push || pending);
  assign err_set = ovf || csum_bad;
  assign restart = start &&
                   (state_q == S_IDLE || state_q == S_DONE);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (restart),
    .push_i    (push),
    .flush_i   (flush),
    .data_i    (s_data),
    .word_o    (word),
    .pending_o (pending),
    .emit_o    (emit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            idx_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            last_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (take) begin
            sum_q <= sum_nxt;
            if (err_set) err_q <= 1'b1;
            if (emit) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= A_WIDTH'({idx_q, 2'b00});
              wdata_q <= D_WIDTH'(word);
              last_q  <= s_last;
            end else if (s_last) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= err_q || err_set;
            end
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (last_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hold_q  <= err_q;
          end else begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready    = ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;
  assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded random bench for imem_loader (4-word memory).
// Expected writes come from a byte-level model of each whole load.
module tb_imem_loader;

  localparam int MAW  = 2;
  localparam int CAPW = 1 << MAW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic [7:0]     s_data = 8'h00;
  logic           s_ready;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic           busy;
  logic           done;
  logic           err;
  logic [MAW:0]   word_count;
  logic           cpu_hold;

  imem_loader #(
    .D_WIDTH     (32),
    .A_WIDTH     (32),
    .MEM_A_WIDTH (MAW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] bq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("ready_in_write", {31'd0, s_ready}, 32'd0);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_word_count"}, 32'(word_count), 0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 1);
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
  task automatic run_load(input int mode, input int stop_after);
    int          n;
    int          dlen;
    int          gap;
    int          nwr;
    int          t;
    bit          ok;
    bit          eerr;
    logic [7:0]  sum;
    logic [31:0] wd;
    bit          trig[64];
    logic [31:0] ta[64];
    logic [31:0] td[64];
    wr_t         e;

    n = bq.size();
`ifdef IMEM_LOADER_CSUM_EN
    dlen = n - 1;
`else
    dlen = n;
`endif
    foreach (trig[j]) trig[j] = 1'b0;
    nwr = 0;
    for (int w = 0; w < CAPW && 4*w < dlen; w++) begin
      wd = 0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < dlen) wd[8*k +: 8] = bq[4*w + k];
      t = (4*w + 3 < dlen) ? 4*w + 3 : n - 1;
      trig[t] = 1'b1;
      ta[t] = 32'(4*w);
      td[t] = wd;
      nwr++;
    end
    sum = 0;
    foreach (bq[j]) sum += bq[j];
    eerr = (n > 4*CAPW);
`ifdef IMEM_LOADER_CSUM_EN
    if (sum != 8'd0) eerr = 1'b1;
`endif

    @(posedge clk); #1;
    start = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data = bq[i];
      s_last = (i == n - 1);
      start = (i != n - 1) && ($urandom_range(0, 5) == 0);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (s_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        fail_now("handshake_timeout");
        s_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (trig[i]) begin
        e.cyc = cyc + 1;
        e.addr = ta[i];
        e.data = td[i];
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last = 1'b0;
      start = 1'b0;
    end
    if (stop_after >= 0) return;

    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
    chk("done", {31'd0, done}, 1);
    chk("busy_done", {31'd0, busy}, 0);
    chk("ready_done", {31'd0, s_ready}, 0);
    chk("err", {31'd0, err}, {31'd0, eerr});
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, eerr});
    chk("word_count", 32'(word_count), 32'(nwr));
    chk("pending_writes", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int len;
    logic [7:0] s;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b1;

    bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(0, -1);

    bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(0, -1);

    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, -1);

    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'(i + 1));
    run_load(2, -1);

    bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(0, 6);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset("midload_reset");
    chk("midload_pending", 32'(exp_q.size()), 0);
    @(posedge clk); #1 rst = 1'b1;
    bq = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    run_load(0, -1);

    bq = {8'h10, 8'h20, 8'h30, 8'hA0};
    run_load(0, -1);
    bq = {8'h10, 8'h20, 8'h30, 8'hA1};
    run_load(0, -1);
    bq = {8'h9C};
    run_load(0, -1);

    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 22);
      bq.delete();
      s = 0;
      for (int i = 0; i < len; i++) begin
        bq.push_back(8'($urandom));
        if (i < len - 1) s += bq[i];
      end
      if ($urandom_range(0, 1) == 1) bq[len - 1] = 8'(-s);
      run_load($urandom_range(0, 2), -1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
